// File: rtl/cpu_pkg.sv
// Shared definitions for the program-counter stage: widths, pc_src encodings
// and default exception/reset vectors.
package cpu_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned JUMP_W = 26;
  localparam int unsigned IMM_W  = 16;

  typedef enum logic [1:0] {
    PCSRC_SEQ    = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_REG    = 2'b11
  } pcsrc_e;

  localparam logic [ADDR_W-1:0] DEF_RESET_VEC = 32'h8000_0000;
  localparam logic [ADDR_W-1:0] DEF_IRQ_VEC   = 32'h8000_0004;
  localparam logic [ADDR_W-1:0] DEF_EXC_VEC   = 32'h8000_0008;

endpackage

// File: rtl/irq_latch.sv
// Rising-edge detector on the external interrupt line plus a sticky pending
// flag that clears only when the interrupt is actually taken.
module irq_latch (
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  input  logic take,
  output logic pending
);

  logic irq_d_q, irq_d_d;
  logic pending_q, pending_d;
  logic rise;

  // A new edge in the same cycle as a take keeps the flag set for that new event.
  always_comb begin
    rise      = irq_in & ~irq_d_q;
    irq_d_d   = irq_in;
    pending_d = rise | (pending_q & ~take);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_d_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      irq_d_q   <= irq_d_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/pc_unit.sv
// Program counter stage: next-PC selection, kernel-mode tracking via pc[31],
// interrupt/undefined-instruction redirects and retired-instruction counter.
module pc_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] IRQ_VEC   = DEF_IRQ_VEC,
  parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        irq_in,
  input  logic        undef_inst,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] jump_target,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        kernel_mode,
  output logic        irq_take,
  output logic [31:0] exc_link,
  output logic [31:0] retired
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] retired_q, retired_d;
  logic [ADDR_W-1:0] pc_plus4_c;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] br_target;
  logic              irq_pending;

  irq_latch u_irq (
    .clk     (clk),
    .reset   (reset),
    .irq_in  (irq_in),
    .take    (irq_take),
    .pending (irq_pending)
  );

  // Kernel code is never interrupted; a stalled instruction is not squashed.
  assign irq_take = irq_pending & ~pc_q[ADDR_W-1] & ~stall;

  always_comb begin
    pc_plus4_c = pc_q + ADDR_W'(4);
    br_off     = {{(ADDR_W-IMM_W-2){imm16[IMM_W-1]}}, imm16, 2'b00};
    br_target  = pc_plus4_c + br_off;
    br_target[ADDR_W-1] = pc_q[ADDR_W-1];

    pc_d      = pc_q;
    retired_d = retired_q;

    if (!stall) begin
      if (irq_take) begin
        pc_d = IRQ_VEC;
      end else if (undef_inst) begin
        pc_d = EXC_VEC;
      end else begin
        retired_d = retired_q + ADDR_W'(1);
        case (pcsrc_e'(pc_src))
          PCSRC_BRANCH: pc_d = branch_taken ? br_target : pc_plus4_c;
          PCSRC_JUMP:   pc_d = {pc_q[ADDR_W-1], pc_plus4_c[30:28], jump_target, 2'b00};
          // Mode bit can only be cleared by a register jump, never set.
          PCSRC_REG:    pc_d = {pc_q[ADDR_W-1] & jr_target[ADDR_W-1], jr_target[ADDR_W-2:0]};
          default:      pc_d = pc_plus4_c;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_VEC;
      retired_q <= '0;
    end else begin
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_c;
  assign kernel_mode = pc_q[ADDR_W-1];
  assign exc_link    = pc_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: sequential flow, branches, jumps, mode changes,
// interrupt pending/take behaviour, undefined-instruction redirect and reset.
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        irq_in;
  logic        undef_inst;
  logic [1:0]  pc_src;
  logic        branch_taken;
  logic [15:0] imm16;
  logic [25:0] jump_target;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        kernel_mode;
  logic        irq_take;
  logic [31:0] exc_link;
  logic [31:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  pc_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .irq_in       (irq_in),
    .undef_inst   (undef_inst),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .imm16        (imm16),
    .jump_target  (jump_target),
    .jr_target    (jr_target),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .kernel_mode  (kernel_mode),
    .irq_take     (irq_take),
    .exc_link     (exc_link),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic jr(input logic [31:0] tgt);
    pc_src    = 2'b11;
    jr_target = tgt;
    step();
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; irq_in = 1'b0; undef_inst = 1'b0;
    pc_src = 2'b00; branch_taken = 1'b0; imm16 = '0; jump_target = '0; jr_target = '0;
    step();
    reset = 1'b0;
    chk("reset_pc", pc, 32'h8000_0000);
    chk("reset_kernel", 32'(kernel_mode), 32'd1);
    chk("reset_take", 32'(irq_take), 32'd0);
    chk("reset_retired", retired, 32'd0);
    chk("reset_pc_plus4", pc_plus4, 32'h8000_0004);

    step(); chk("seq1", pc, 32'h8000_0004);
    step(); chk("seq2", pc, 32'h8000_0008);
    step(); chk("seq3", pc, 32'h8000_000C);
    chk("seq_retired", retired, 32'd3);

    jr(32'h8000_0100);
    chk("jr_kernel_pc", pc, 32'h8000_0100);
    chk("jr_kernel_mode", 32'(kernel_mode), 32'd1);
    jr(32'h0040_0020);
    chk("jr_to_user_pc", pc, 32'h0040_0020);
    chk("jr_to_user_mode", 32'(kernel_mode), 32'd0);
    jr(32'h8000_0000);
    chk("jr_user_no_escalate", pc, 32'h0000_0000);
    chk("jr_user_mode", 32'(kernel_mode), 32'd0);

    jr(32'h0040_0010);
    pc_src = 2'b01; branch_taken = 1'b1; imm16 = 16'hFFFE;
    step();
    chk("branch_taken_back", pc, 32'h0040_000C);
    jr(32'h0040_0010);
    pc_src = 2'b01; branch_taken = 1'b0;
    step();
    chk("branch_not_taken", pc, 32'h0040_0014);
    pc_src = 2'b10; jump_target = 26'h010_0000;
    step();
    chk("jump", pc, 32'h0040_0000);
    chk("jump_retired", retired, 32'd11);

    jr(32'h7FFF_FFFC);
    chk("pc_plus4_cross", pc_plus4, 32'h8000_0000);
    pc_src = 2'b01; branch_taken = 1'b1; imm16 = 16'h0000;
    step();
    chk("branch_bit31_forced", pc, 32'h0000_0000);
    chk("branch_retired", retired, 32'd13);

    // Interrupt arriving in kernel mode stays pending until user mode.
    reset = 1'b1; pc_src = 2'b00;
    step();
    reset = 1'b0;
    step(); step(); step(); step();
    chk("irq_pre_pc", pc, 32'h8000_0010);
    irq_in = 1'b1;
    step();
    chk("irq_kernel_no_take", 32'(irq_take), 32'd0);
    step();
    chk("irq_kernel_no_take2", 32'(irq_take), 32'd0);
    jr(32'h0040_0000);
    chk("irq_take_user", 32'(irq_take), 32'd1);
    chk("irq_exc_link", exc_link, 32'h0040_0000);
    chk("irq_pre_retired", retired, 32'd7);
    step();
    chk("irq_vector", pc, 32'h8000_0004);
    chk("irq_retired_held", retired, 32'd7);
    jr(32'h0040_0000);
    chk("irq_cleared", 32'(irq_take), 32'd0);
    chk("irq_clear_pc", pc, 32'h0040_0000);

    // Undefined instruction held by stall, then redirected.
    pc_src = 2'b00;
    step(); step();
    chk("undef_pre_pc", pc, 32'h0040_0008);
    undef_inst = 1'b1; stall = 1'b1;
    step();
    chk("undef_stall_pc", pc, 32'h0040_0008);
    chk("undef_stall_retired", retired, 32'd10);
    stall = 1'b0;
    step();
    chk("undef_vector", pc, 32'h8000_0008);
    chk("undef_retired", retired, 32'd10);
    undef_inst = 1'b0;

    // New edge coinciding with a take keeps the interrupt pending.
    irq_in = 1'b0;
    step();
    irq_in = 1'b1;
    step();
    irq_in = 1'b0;
    jr(32'h0040_0000);
    chk("coinc_take1", 32'(irq_take), 32'd1);
    irq_in = 1'b1;
    step();
    chk("coinc_vector", pc, 32'h8000_0004);
    jr(32'h0040_0040);
    chk("coinc_take2", 32'(irq_take), 32'd1);
    chk("coinc_exc_link", exc_link, 32'h0040_0040);
    chk("coinc_retired", retired, 32'd14);
    step();
    jr(32'h0040_0040);
    chk("coinc_cleared", 32'(irq_take), 32'd0);
    chk("coinc_retired2", retired, 32'd15);

    // Mid-run reset.
    reset = 1'b1; irq_in = 1'b0; pc_src = 2'b00;
    step();
    reset = 1'b0;
    chk("rst2_pc", pc, 32'h8000_0000);
    chk("rst2_retired", retired, 32'd0);
    chk("rst2_kernel", 32'(kernel_mode), 32'd1);
    jr(32'h0040_0000);
    chk("rst2_no_pending", 32'(irq_take), 32'd0);
    chk("rst2_retired1", retired, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
